// File: rtl/ebi_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : ebi_bridge
//  Purpose  : Bridge between the MCU external bus (EBI) and the FPGA
//             command/sample FIFOs. Bus strobes are synchronised and
//             edge-qualified. CMD_WORDS bus words are assembled into one
//             command and pushed to the command FIFO. Bus reads of the
//             SAMPLE register pop the sample FIFO. A status register carries
//             the sticky overflow/underflow flags, and a maskable level
//             interrupt is driven from it.
//
//  Ports    : clk, rst (async, active-low)
//             data_in/data_out/addr/rd/wr/cs      - external bus
//             cmd_fifo_data_in/cmd_fifo_wr_en      - command FIFO push side
//             cmd_fifo_* flags                     - command FIFO status
//             sample_fifo_data_out/sample_fifo_rd_en - sample FIFO pop side
//                                                    (first-word-fall-through)
//             sample_fifo_* flags                  - sample FIFO status
//             irq                                  - registered level interrupt
//
//  Address map: 0 STATUS (RO), 1 IRQ_MASK (RW, 11 bits), 2 CLEAR (W1C on
//               STATUS[9:8]), 3 SAMPLE (RO, read pops), 4.. CMD words (WO)
//
//  Revision : 1.0 - initial release
// ============================================================================
module ebi_bridge #(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 19,
    parameter int CMD_WORDS   = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [DATA_W-1:0]           data_in,
    output logic [DATA_W-1:0]           data_out,
    input  logic [ADDR_W-1:0]           addr,
    input  logic                        rd,
    input  logic                        wr,
    input  logic                        cs,
    output logic [CMD_WORDS*DATA_W-1:0] cmd_fifo_data_in,
    output logic                        cmd_fifo_wr_en,
    input  logic                        cmd_fifo_almost_full,
    input  logic                        cmd_fifo_full,
    input  logic                        cmd_fifo_almost_empty,
    input  logic                        cmd_fifo_empty,
    input  logic [DATA_W-1:0]           sample_fifo_data_out,
    output logic                        sample_fifo_rd_en,
    input  logic                        sample_fifo_almost_full,
    input  logic                        sample_fifo_full,
    input  logic                        sample_fifo_almost_empty,
    input  logic                        sample_fifo_empty,
    output logic                        irq
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WRITE   = 3'd1,
        COMMIT  = 3'd2,
        READ    = 3'd3,
        RELEASE = 3'd4
    } state_t;

    state_t r_state;
    state_t w_next;

    // ------------------------------------------------------------------
    // Strobe synchronisers and edge qualification
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic [SYNC_STAGES-1:0] r_rd_sync;
    logic [SYNC_STAGES-1:0] r_wr_sync;
    logic                   r_wr_lvl_d;
    logic                   r_rd_lvl_d;

    logic w_cs_s, w_rd_s, w_wr_s;
    logic w_wr_lvl, w_rd_lvl;
    logic w_wr_go, w_rd_go;

    assign w_cs_s   = r_cs_sync[SYNC_STAGES-1];
    assign w_rd_s   = r_rd_sync[SYNC_STAGES-1];
    assign w_wr_s   = r_wr_sync[SYNC_STAGES-1];
    assign w_wr_lvl = w_cs_s & w_wr_s;
    assign w_rd_lvl = w_cs_s & w_rd_s;

    // An edge only counts when the opposite strobe is low, so cs&rd&wr
    // together never starts an access. Tracking the raw levels (not the
    // qualified ones) keeps a late-dropping strobe from faking a new edge.
    assign w_wr_go  = w_wr_lvl & ~r_wr_lvl_d & ~w_rd_s;
    assign w_rd_go  = w_rd_lvl & ~r_rd_lvl_d & ~w_wr_s;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cs_sync  <= '0;
            r_rd_sync  <= '0;
            r_wr_sync  <= '0;
            r_wr_lvl_d <= 1'b0;
            r_rd_lvl_d <= 1'b0;
        end else begin
            r_cs_sync  <= {r_cs_sync[SYNC_STAGES-2:0], cs};
            r_rd_sync  <= {r_rd_sync[SYNC_STAGES-2:0], rd};
            r_wr_sync  <= {r_wr_sync[SYNC_STAGES-2:0], wr};
            r_wr_lvl_d <= w_wr_lvl;
            r_rd_lvl_d <= w_rd_lvl;
        end
    end

    // ------------------------------------------------------------------
    // Registers and address decode
    // ------------------------------------------------------------------
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_data;
    logic [DATA_W-1:0] r_cmd [CMD_WORDS];
    logic [10:0]       r_mask;
    logic              r_ovf;
    logic              r_unf;
    logic              r_partial;
    logic              r_smp_rd_en;

    logic              w_is_mask, w_is_clear, w_is_sample, w_is_status;
    logic              w_is_cmd, w_is_last;
    logic [2:0]        w_cmd_idx;
    logic [DATA_W-1:0] w_status;
    logic [DATA_W-1:0] w_rd_data;
    logic              w_ovf_set, w_ovf_clr, w_unf_set, w_unf_clr;
    logic              w_cmd_push;

    assign w_is_status = (r_addr == ADDR_W'(0));
    assign w_is_mask   = (r_addr == ADDR_W'(1));
    assign w_is_clear  = (r_addr == ADDR_W'(2));
    assign w_is_sample = (r_addr == ADDR_W'(3));
    assign w_is_cmd    = (r_addr >= ADDR_W'(4)) && (r_addr < ADDR_W'(4 + CMD_WORDS));
    // Word index only needs the low bits: CMD_WORDS <= 8 and the range
    // check above already rejects aliases.
    assign w_cmd_idx   = 3'(r_addr[2:0] - 3'd4);
    assign w_is_last   = (w_cmd_idx == 3'(CMD_WORDS - 1));

    always_comb begin
        w_status       = '0;
        w_status[10:0] = {r_partial, r_unf, r_ovf,
                          sample_fifo_full, sample_fifo_almost_full,
                          sample_fifo_almost_empty, sample_fifo_empty,
                          cmd_fifo_full, cmd_fifo_almost_full,
                          cmd_fifo_almost_empty, cmd_fifo_empty};
    end

    always_comb begin
        w_rd_data = '0;
        if (w_is_status) begin
            w_rd_data = w_status;
        end else if (w_is_mask) begin
            w_rd_data[10:0] = r_mask;
        end else if (w_is_sample && !sample_fifo_empty) begin
            w_rd_data = sample_fifo_data_out;
        end
    end

    // Sticky flag events; set takes priority over clear in the update below.
    assign w_ovf_set = (r_state == WRITE) & w_is_cmd & w_is_last & cmd_fifo_full;
    assign w_ovf_clr = (r_state == WRITE) & w_is_clear & r_data[8];
    assign w_unf_set = (r_state == READ) & w_is_sample & sample_fifo_empty;
    assign w_unf_clr = (r_state == WRITE) & w_is_clear & r_data[9];

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_cmd_push = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_wr_go) begin
                    w_next = WRITE;
                end else if (w_rd_go) begin
                    w_next = READ;
                end
            end
            WRITE: begin
                if (w_is_cmd && w_is_last && !cmd_fifo_full) begin
                    w_next = COMMIT;
                end else begin
                    w_next = RELEASE;
                end
            end
            COMMIT: begin
                w_cmd_push = 1'b1;
                w_next     = RELEASE;
            end
            READ: begin
                w_next = RELEASE;
            end
            RELEASE: begin
                if (!w_rd_s && !w_wr_s) begin
                    w_next = IDLE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_addr      <= '0;
            r_data      <= '0;
            r_mask      <= '0;
            r_ovf       <= 1'b0;
            r_unf       <= 1'b0;
            r_partial   <= 1'b0;
            r_smp_rd_en <= 1'b0;
            data_out    <= '0;
            irq         <= 1'b0;
            for (int k = 0; k < CMD_WORDS; k++) begin
                r_cmd[k] <= '0;
            end
        end else begin
            r_smp_rd_en <= 1'b0;
            irq         <= |(w_status[10:0] & r_mask);
            r_ovf       <= w_ovf_set | (r_ovf & ~w_ovf_clr);
            r_unf       <= w_unf_set | (r_unf & ~w_unf_clr);

            // Bus address/data are captured on the qualified edge cycle.
            if (r_state == IDLE && (w_wr_go || w_rd_go)) begin
                r_addr <= addr;
                r_data <= data_in;
            end

            if (r_state == WRITE) begin
                if (w_is_cmd) begin
                    for (int k = 0; k < CMD_WORDS; k++) begin
                        if (w_cmd_idx == 3'(k)) begin
                            r_cmd[k] <= r_data;
                        end
                    end
                    r_partial <= 1'b1;
                end
                if (w_is_mask) begin
                    r_mask <= r_data[10:0];
                end
            end

            if (r_state == COMMIT) begin
                r_partial <= 1'b0;
            end

            if (r_state == READ) begin
                data_out    <= w_rd_data;
                r_smp_rd_en <= w_is_sample & ~sample_fifo_empty;
            end
        end
    end

    // Word 0 sits in the most significant slice of the command.
    for (genvar k = 0; k < CMD_WORDS; k++) begin : g_cmd_out
        assign cmd_fifo_data_in[(CMD_WORDS-k)*DATA_W-1 -: DATA_W] = r_cmd[k];
    end

    assign cmd_fifo_wr_en    = w_cmd_push;
    assign sample_fifo_rd_en = r_smp_rd_en;

endmodule
`default_nettype wire
